// File: rtl/drive_pkg.sv
// Shared types, ASCII command constants and the byte decoder for the
// drive command arbiter.
package drive_pkg;

    typedef enum logic [2:0] {
        STOP  = 3'd0,
        FWD   = 3'd1,
        REV   = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } drive_cmd_t;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        DRIVE   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    localparam logic [7:0] CMD_F = 8'h46;
    localparam logic [7:0] CMD_B = 8'h42;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_S = 8'h53;

    typedef struct packed {
        logic       ok;
        drive_cmd_t cmd;
    } decode_t;

    // ok=0 marks a byte that is not one of the five drive letters.
    function automatic decode_t decode_byte(input logic [7:0] b);
        decode_t r;
        r.ok  = 1'b1;
        r.cmd = STOP;
        case (b)
            CMD_F:   r.cmd = FWD;
            CMD_B:   r.cmd = REV;
            CMD_L:   r.cmd = LEFT;
            CMD_R:   r.cmd = RIGHT;
            CMD_S:   r.cmd = STOP;
            default: r.ok  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/drive_command_arbiter_if.sv
// Byte handshake between the UART receive buffer (master) and the arbiter (slave).
interface drive_command_arbiter_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] cmd_data;
    logic                 cmd_valid;
    logic                 cmd_ready;

    modport master (output cmd_data, output cmd_valid, input cmd_ready);
    modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/prox_sync_debounce.sv
// Two-flop synchroniser for the proximity flag plus the quiet-time counter
// that decides when an obstacle has really gone away.
module prox_sync_debounce #(
    parameter int unsigned CLEAR_CYCLES = 25_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_prox_near,
    input  logic i_clear,
    output logic o_prox_s,
    output logic o_prox_clear
);
    localparam logic [31:0] CNT_LAST = 32'(CLEAR_CYCLES - 1);

    logic        r_meta;
    logic        r_sync;
    logic [31:0] r_cnt;

    // Bring the asynchronous proximity flag into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_prox_near;
            r_sync <= r_meta;
        end
    end

    // Count consecutive clear cycles; any near sample restarts the window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || r_sync) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_prox_s     = r_sync;
    // The final cycle of the window must itself be clear.
    assign o_prox_clear = !r_sync && (r_cnt == CNT_LAST);

endmodule

// File: rtl/drive_command_arbiter.sv
// Decodes one ASCII drive byte per UART frame into a motor command, with a
// proximity override on forward motion and a command watchdog.
//
// state   | meaning
// STOPPED | motors stopped, waiting for a motion byte
// DRIVE   | motors running the latched command, watchdog counting
// BLOCKED | forward blocked by an obstacle, motors stopped
module drive_command_arbiter
    import drive_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned TIMEOUT_MS   = 500,
    parameter int unsigned CLEAR_CYCLES = 25_000_000,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                    i_clk_50,
    input  logic                    i_reset,
    drive_command_arbiter_if.slave  cmd_bus,
    input  logic                    i_prox_near,
    output drive_cmd_t              o_drive_cmd,
    output logic                    o_blocked,
    output logic                    o_timeout_pulse,
    output logic [7:0]              o_bad_cmd_count
);
    localparam logic [31:0] TIMEOUT_CYCLES = 32'((CLK_HZ / 1000) * TIMEOUT_MS);
    // Expiry is decided on the edge where the count would reach TIMEOUT_CYCLES-1.
    localparam logic [31:0] WD_LAST        = TIMEOUT_CYCLES - 32'd2;

    state_t               r_state;
    drive_cmd_t           r_drive;
    logic                 r_ready;
    logic                 r_valid_q;
    logic                 r_blocked;
    logic                 r_pulse;
    logic [7:0]           r_bad;
    logic [31:0]          r_wd;

    logic [DATA_BITS-1:0] w_data;
    decode_t              w_dec;
    logic                 w_accept;
    logic                 w_motion;
    logic                 w_is_stop;
    logic                 w_bad;
    logic                 w_fwd_in;
    logic                 w_block;
    logic                 w_blk_release;
    logic                 w_prox_s;
    logic                 w_prox_clear;
    logic                 w_clear;

    assign w_data        = cmd_bus.cmd_data;
    assign w_dec         = decode_byte(8'(w_data));
    assign w_accept      = cmd_bus.cmd_valid && !r_valid_q && r_ready;
    assign w_motion      = w_accept && w_dec.ok && (w_dec.cmd != STOP);
    assign w_is_stop     = w_accept && w_dec.ok && (w_dec.cmd == STOP);
    assign w_bad         = w_accept && !w_dec.ok;
    assign w_fwd_in      = w_motion && (w_dec.cmd == FWD);
    // Latched or incoming forward under an obstacle wins over any byte.
    assign w_block       = w_prox_s && (w_fwd_in || ((r_state == DRIVE) && (r_drive == FWD)));
    assign w_blk_release = (r_state == BLOCKED) && w_motion && (w_dec.cmd != FWD);
    // Quiet window only runs while blocked and restarts on every new block.
    assign w_clear       = (r_state != BLOCKED) || w_blk_release;

    prox_sync_debounce #(
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) u_prox (
        .i_clk        (i_clk_50),
        .i_rst        (i_reset),
        .i_prox_near  (i_prox_near),
        .i_clear      (w_clear),
        .o_prox_s     (w_prox_s),
        .o_prox_clear (w_prox_clear)
    );

    // Control FSM with watchdog, edge detect and bad-byte counter; all outputs registered.
    always_ff @(posedge i_clk_50 or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= STOPPED;
            r_drive   <= STOP;
            r_ready   <= 1'b0;
            r_valid_q <= 1'b1;
            r_blocked <= 1'b0;
            r_pulse   <= 1'b0;
            r_bad     <= 8'd0;
            r_wd      <= 32'd0;
        end else begin
            r_valid_q <= cmd_bus.cmd_valid;
            r_ready   <= 1'b1;
            r_pulse   <= 1'b0;
            if (w_bad && (r_bad != 8'hFF)) begin
                r_bad <= r_bad + 8'd1;
            end
            case (r_state)
                STOPPED: begin
                    if (w_block) begin
                        r_state   <= BLOCKED;
                        r_blocked <= 1'b1;
                    end else if (w_motion) begin
                        r_state <= DRIVE;
                        r_drive <= w_dec.cmd;
                        r_wd    <= 32'd0;
                    end
                end
                DRIVE: begin
                    if (w_block) begin
                        r_state   <= BLOCKED;
                        r_blocked <= 1'b1;
                        r_drive   <= STOP;
                    end else if (w_motion) begin
                        r_drive <= w_dec.cmd;
                        r_wd    <= 32'd0;
                    end else if (w_is_stop) begin
                        r_state <= STOPPED;
                        r_drive <= STOP;
                    end else if (r_wd == WD_LAST) begin
                        r_state <= STOPPED;
                        r_drive <= STOP;
                        r_pulse <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 32'd1;
                    end
                end
                BLOCKED: begin
                    if (w_blk_release) begin
                        r_state   <= DRIVE;
                        r_blocked <= 1'b0;
                        r_drive   <= w_dec.cmd;
                        r_wd      <= 32'd0;
                    end else if (w_prox_clear) begin
                        r_state   <= STOPPED;
                        r_blocked <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= STOPPED;
                    r_drive   <= STOP;
                    r_blocked <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_bus.cmd_ready = r_ready;
    assign o_drive_cmd       = r_drive;
    assign o_blocked         = r_blocked;
    assign o_timeout_pulse   = r_pulse;
    assign o_bad_cmd_count   = r_bad;

endmodule
